pingpong_frame_reader: RTL and testbench

- Read-side consumer of the ping-pong sample buffer.
- On each buffer-ready pulse it drains exactly DEPTH samples over the buffer's read valid/ready stream and forwards them to a downstream valid/ready stream, tagged with first/last/index.
- Computes the frame's peak absolute value and reports frames that were signalled while a drain was already in progress.
- Sits between the ping-pong buffer and the DSP/feature-extraction stage.

---
 rtl/pingpong_frame_reader_pkg.sv | 11 +
 rtl/stream_pipe_reg.sv | 41 ++++
 rtl/pingpong_frame_reader.sv | 163 ++++++++++++++++
 tb/tb_pingpong_frame_reader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_frame_reader_pkg.sv
// Shared types for the ping-pong frame reader.
//   reader_state_e : reader FSM state (IDLE, DRAIN, FLUSH), 2-bit encoding.
package pingpong_frame_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } reader_state_e;

endpackage

// File: rtl/stream_pipe_reg.sv
// One-entry valid/ready pipeline register. A new word may be loaded in the
// same cycle the held word is consumed, which gives full throughput.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   data_i, valid_i  : upstream payload and valid
//   ready_o          : register can accept (empty, or being drained)
//   data_o, valid_o  : held payload and valid
//   ready_i          : downstream accepts the held word
module stream_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    input  logic         ready_i
);

    logic [W-1:0] data_q;
    logic         valid_q;

    assign ready_o = !valid_q || ready_i;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pingpong_frame_reader.sv
// Read-side consumer of the ping-pong sample buffer. Each buffer-ready pulse
// drains exactly DEPTH samples from the buffer stream and forwards them
// downstream tagged with first/last/index, tracking the frame peak |sample|.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   buffer_ready_i            : one-cycle pulse, a full frame can be read
//   read_data_i/valid_i/ready_o : buffer read stream
//   m_data_o/valid_o/ready_i  : downstream stream
//   m_first_o, m_last_o, m_index_o : position of the sample in its frame
//   frame_done_o              : pulse, last sample left the output register
//   frame_peak_o              : peak |sample| of the last completed frame
//   frame_missed_o            : pulse, buffer_ready_i arrived while busy
//   busy_o                    : reader is not IDLE
module pingpong_frame_reader
    import pingpong_frame_reader_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         buffer_ready_i,
    input  logic signed [WIDTH-1:0]      read_data_i,
    input  logic                         read_valid_i,
    output logic                         read_ready_o,
    output logic signed [WIDTH-1:0]      m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         m_first_o,
    output logic                         m_last_o,
    output logic [ADDR_WIDTH-1:0]        m_index_o,
    output logic                         frame_done_o,
    output logic [WIDTH-2:0]             frame_peak_o,
    output logic                         frame_missed_o,
    output logic                         busy_o
);

    localparam int unsigned PW = WIDTH + 2 + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    // |x| in WIDTH-1 bits; the most negative value has no positive
    // counterpart and saturates to the largest magnitude.
    function automatic logic [WIDTH-2:0] sat_abs(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] neg;
        if (x == {1'b1, {(WIDTH-1){1'b0}}}) begin
            return {(WIDTH-1){1'b1}};
        end
        neg = -x;
        return x[WIDTH-1] ? neg[WIDTH-2:0] : x[WIDTH-2:0];
    endfunction

    reader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-2:0]      peak_q, peak_d;
    logic [WIDTH-2:0]      frame_peak_q, frame_peak_d;
    logic                  done_q, done_d;
    logic                  missed_q, missed_d;

    logic                  pipe_ready;
    logic                  pipe_in_valid;
    logic                  in_xfer;
    logic                  out_xfer;
    logic [PW-1:0]         pipe_in;
    logic [PW-1:0]         pipe_out;
    logic [WIDTH-2:0]      sample_abs;

    // Only DRAIN offers the source a ready; the pipe register's own ready
    // already folds in downstream backpressure.
    assign pipe_in_valid = (state_q == DRAIN) && read_valid_i;
    assign read_ready_o  = (state_q == DRAIN) && pipe_ready;
    assign in_xfer       = pipe_in_valid && pipe_ready;
    assign out_xfer      = m_valid_o && m_ready_i;
    assign sample_abs    = sat_abs(read_data_i);

    assign pipe_in = {read_data_i, (count_q == '0), (count_q == LAST_IDX), count_q};

    stream_pipe_reg #(
        .W (PW)
    ) u_out_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (pipe_in),
        .valid_i (pipe_in_valid),
        .ready_o (pipe_ready),
        .data_o  (pipe_out),
        .valid_o (m_valid_o),
        .ready_i (m_ready_i)
    );

    assign m_data_o  = pipe_out[PW-1 -: WIDTH];
    assign m_first_o = pipe_out[ADDR_WIDTH + 1];
    assign m_last_o  = pipe_out[ADDR_WIDTH];
    assign m_index_o = pipe_out[ADDR_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        peak_d       = peak_q;
        frame_peak_d = frame_peak_q;
        done_d       = 1'b0;
        // A frame signalled while busy is reported but otherwise dropped.
        missed_d     = buffer_ready_i && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (buffer_ready_i) begin
                    state_d = DRAIN;
                    count_d = '0;
                    peak_d  = '0;
                end
            end
            DRAIN: begin
                if (in_xfer) begin
                    count_d = count_q + 1'b1;
                    if (sample_abs > peak_q) begin
                        peak_d = sample_abs;
                    end
                    if (count_q == LAST_IDX) begin
                        state_d = FLUSH;
                        count_d = '0;
                    end
                end
            end
            FLUSH: begin
                // Only the last sample can be held here, so its consumption
                // completes the frame.
                if (out_xfer) begin
                    state_d      = IDLE;
                    done_d       = 1'b1;
                    frame_peak_d = peak_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            peak_q       <= '0;
            frame_peak_q <= '0;
            done_q       <= 1'b0;
            missed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            peak_q       <= peak_d;
            frame_peak_q <= frame_peak_d;
            done_q       <= done_d;
            missed_q     <= missed_d;
        end
    end

    assign frame_done_o   = done_q;
    assign frame_peak_o   = frame_peak_q;
    assign frame_missed_o = missed_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_pingpong_frame_reader.sv
// Directed bench for pingpong_frame_reader (WIDTH=32, DEPTH=16).
module tb_pingpong_frame_reader;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               buffer_ready_i;
    logic signed [31:0] read_data_i;
    logic               read_valid_i;
    logic               read_ready_o;
    logic signed [31:0] m_data_o;
    logic               m_valid_o;
    logic               m_ready_i;
    logic               m_first_o;
    logic               m_last_o;
    logic [3:0]         m_index_o;
    logic               frame_done_o;
    logic [30:0]        frame_peak_o;
    logic               frame_missed_o;
    logic               busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [31:0] src [16];
    logic [30:0]        last_peak;

    always #5 clk_i = ~clk_i;

    pingpong_frame_reader #(
        .WIDTH (32),
        .DEPTH (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .buffer_ready_i (buffer_ready_i),
        .read_data_i    (read_data_i),
        .read_valid_i   (read_valid_i),
        .read_ready_o   (read_ready_o),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_first_o      (m_first_o),
        .m_last_o       (m_last_o),
        .m_index_o      (m_index_o),
        .frame_done_o   (frame_done_o),
        .frame_peak_o   (frame_peak_o),
        .frame_missed_o (frame_missed_o),
        .busy_o         (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   m_data_o,       0);
        check({tag, "_valid"},  m_valid_o,      0);
        check({tag, "_first"},  m_first_o,      0);
        check({tag, "_last"},   m_last_o,       0);
        check({tag, "_index"},  m_index_o,      0);
        check({tag, "_done"},   frame_done_o,   0);
        check({tag, "_peak"},   frame_peak_o,   0);
        check({tag, "_missed"}, frame_missed_o, 0);
        check({tag, "_busy"},   busy_o,         0);
        check({tag, "_rdy"},    read_ready_o,   0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) src[i] = i;
    endtask

    // mode: 0 smooth, 1 backpressure 1,0,0,1, 2 missed pulses, 3 source gap
    // rst_after > 0: reset once that many samples are consumed and one is held
    task automatic run_frame(input int mode, input int rst_after,
                             input logic [30:0] exp_peak, input int exp_missed);
        int          k, si, cyc, first_in, n_done, n_miss, gap_cnt;
        bit          stalled_prev, saw_drop, fin, in_x, out_x, gap;
        logic [31:0] prev_data;
        logic [3:0]  prev_idx;
        bit [3:0]    pat;
        pat = 4'b1001;
        k = 0; si = 0; cyc = 0; first_in = -1; n_done = 0; n_miss = 0; gap_cnt = 0;
        stalled_prev = 0; saw_drop = 0; fin = 0;
        prev_data = '0; prev_idx = '0;

        @(negedge clk_i);
        check("peak_held", frame_peak_o, last_peak);
        m_ready_i      = 1'b1;
        read_valid_i   = 1'b0;
        buffer_ready_i = 1'b1;
        #1;
        check("rdy_in_idle", read_ready_o, 0);
        check("busy_idle", busy_o, 0);

        while (!fin) begin
            @(negedge clk_i);
            buffer_ready_i = 1'b0;
            if (rst_after > 0 && k == rst_after && m_valid_o) begin
                rst_i = 1'b1;
                @(posedge clk_i);
                @(negedge clk_i);
                check_all_zero("mid_rst");
                check("mid_rst_no_done", n_done, 0);
                rst_i     = 1'b0;
                last_peak = '0;
                return;
            end
            if (frame_done_o) begin
                n_done++;
                check("done_after_last", k, 16);
                check("done_busy", busy_o, 0);
                check("done_valid", m_valid_o, 0);
                fin = 1;
            end
            if (frame_missed_o) n_miss++;
            if (stalled_prev) begin
                check("stall_data", m_data_o, prev_data);
                check("stall_index", m_index_o, prev_idx);
            end
            if (mode == 3 && k == 5 && !m_valid_o) saw_drop = 1;

            m_ready_i = (mode == 1) ? pat[cyc % 4] : 1'b1;
            gap = (mode == 3 && si == 5 && gap_cnt < 3);
            if (gap) gap_cnt++;
            read_valid_i = (si < 16) && !gap;
            read_data_i  = (si < 16) ? src[si] : 32'sd0;
            #1;
            in_x  = read_valid_i && read_ready_o;
            out_x = m_valid_o && m_ready_i;

            if (mode == 0 && cyc == 0) check("rdy_latency", read_ready_o, 1);
            if (m_valid_o && !m_ready_i) check("rdy_backpressure", read_ready_o, 0);
            if (out_x) begin
                check("out_data", m_data_o, src[k]);
                check("out_index", m_index_o, k);
                check("out_first", m_first_o, k == 0);
                check("out_last", m_last_o, k == 15);
                if (mode == 0) check("out_cycle", cyc, first_in + 1 + k);
                k++;
            end
            if (mode == 2 && in_x && si == 6) buffer_ready_i = 1'b1;
            if (mode == 2 && out_x && k == 16) buffer_ready_i = 1'b1;

            stalled_prev = m_valid_o && !m_ready_i;
            prev_data    = m_data_o;
            prev_idx     = m_index_o;
            if (in_x) begin
                if (first_in < 0) first_in = cyc;
                si++;
            end
            cyc++;
            if (cyc > 400 && !fin) begin
                check("timeout", 1, 0);
                fin = 1;
            end
        end

        @(negedge clk_i);
        check("done_one_cycle", frame_done_o, 0);
        check("missed_clear", frame_missed_o, 0);
        check("idle_after", busy_o, 0);
        check("frame_count", k, 16);
        check("frame_done_cnt", n_done, 1);
        check("frame_missed_cnt", n_miss, exp_missed);
        check("frame_peak", frame_peak_o, exp_peak);
        if (mode == 3) check("gap_valid_drop", saw_drop, 1);
        last_peak = exp_peak;
    endtask

    initial begin
        rst_i          = 1'b1;
        buffer_ready_i = 1'b0;
        read_valid_i   = 1'b0;
        read_data_i    = '0;
        m_ready_i      = 1'b0;
        last_peak      = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;

        load_ramp();
        run_frame(0, 0, 31'd15, 0);
        run_frame(1, 0, 31'd15, 0);

        for (int i = 0; i < 16; i++) src[i] = 0;
        src[0] = 32'sd5;
        src[1] = -32'sd7;
        src[2] = 32'h8000_0000;
        src[3] = 32'sd3;
        run_frame(0, 0, 31'h7FFF_FFFF, 0);

        for (int i = 0; i < 16; i++) src[i] = 0;
        src[0] = -32'sd9;
        src[1] = 32'sd4;
        run_frame(0, 0, 31'd9, 0);

        load_ramp();
        run_frame(2, 0, 31'd15, 2);
        run_frame(0, 0, 31'd15, 0);
        run_frame(0, 9, 31'd15, 0);
        run_frame(0, 0, 31'd15, 0);
        run_frame(3, 0, 31'd15, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
